mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory-access stage directly downstream of the ALU in the Small_MIPS datapath.
//  - Consumes the ALU result and op code.
//  - For LW/SW, drives a single-outstanding request/ready data-memory port, using the ALU result as the address.
//  - For all other ops, forwards the ALU result to writeback.
//  - Flags misaligned accesses and memory timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in ACCESS without mem_ready before abort; 0 = never time out
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  in_valid       in   1   ALU-stage result valid
//  in_ready       out  1   stage accepts input; = (state==IDLE)
//  in_op          in   6   ALU op code (LW 100011, SW 101011, ADDU/ADDIU 100001, JR 001000, NOP 000000)
//  in_alu_result  in   32  ALU data_out: address for LW/SW, result otherwise
//  in_store_data  in   32  rt value for SW
//  in_dest        in   5   destination register number
//  mem_req        out  1   memory request
//  mem_we         out  1   1 = store, 0 = load
//  mem_addr       out  32  word-aligned byte address
//  mem_wdata      out  32  store data
//  mem_ready      in   1   memory completes the request this cycle
//  mem_rdata      in   32  load data, valid when mem_ready=1
//  wb_valid       out  1   one-cycle writeback pulse
//  wb_we          out  1   register write enable (qualifies wb_valid)
//  wb_dest        out  5   destination register
//  wb_data        out  32  writeback data
//  exc_valid      out  1   one-cycle exception pulse
//  exc_code       out  2   01 misaligned LW, 10 misaligned SW, 11 timeout
//  exc_addr       out  32  offending address
// BEHAVIOUR
//  Reset:
//  - Async reset forces state=IDLE, timeout counter=0.
//  - All registered outputs are forced to 0.
//  - in_ready=1 after reset is released.
//  Accept: a transfer occurs at the rising edge where in_valid & in_ready.
//  Non-memory op: result appears on the next cycle.
//  - wb_valid=1 for one cycle, wb_data=in_alu_result, wb_dest=in_dest.
//  - wb_we=1 only for op 100001 with in_dest!=0.
//  - NOP, JR and unknown ops: no wb_valid, no exception.
//  LW/SW, misaligned (addr[1:0]!=0):
//  - No mem_req is issued.
//  - Next cycle: exc_valid=1 with code 01 or 10, exc_addr=address.
//  - Stays in IDLE.
//  LW/SW, aligned:
//  - IDLE -> ACCESS.
//  - From the next cycle, mem_req=1; mem_addr, mem_we and mem_wdata are registered and held stable until completion.
//  - in_ready=0 throughout ACCESS.
//  Completion (mem_req & mem_ready at an edge):
//  - Return to IDLE; mem_req drops the next cycle.
//  - LW: wb_valid=1, wb_we=(dest!=0), wb_data=mem_rdata, one cycle later.
//  - SW: no writeback.
//  - Minimum LW latency: accept -> wb_valid = 2 cycles.
//  Timeout (TIMEOUT_CYCLES>0):
//  - The counter increments for each ACCESS cycle without mem_ready.
//  - When the count reaches TIMEOUT_CYCLES: drop mem_req, exc_valid with code 11, no writeback, go to IDLE.
//  - mem_ready on that same edge takes priority: completion, not timeout.
//  mem_ready while mem_req=0 is ignored.
//  wb_valid and exc_valid are never asserted in the same cycle.
//  Reset mid-ACCESS:
//  - mem_req drops immediately (asynchronously).
//  - The in-flight op is discarded; no wb and no exc.
//  The writeback side has no backpressure.
// STRUCTURE
//  mips_pkg holds:
//  - op code localparams: OP_LW, OP_SW, OP_ADDU, OP_JR, OP_NOP
//  - exc_code_t enum: EXC_NONE, EXC_MIS_LD, EXC_MIS_ST, EXC_TIMEOUT
//  - state_t enum: IDLE, ACCESS
//  No sub-module: the FSM, timeout counter and output registers sit inline.
// TESTING
//  - ADDU r5, result 0x0000_1234 -> next cycle wb_valid=1, wb_we=1, wb_dest=5, wb_data=0x1234.
//  - LW r3 addr 0x100, mem_ready after 3 wait cycles, rdata 0xDEADBEEF
//    -> mem_req held with addr 0x100 for 4 cycles, then wb_data=0xDEADBEEF, wb_dest=3.
//  - SW addr 0x204, data 0xA5A5A5A5, mem_ready in the first req cycle
//    -> mem_we=1, mem_wdata=0xA5A5A5A5, no wb_valid, in_ready back the next cycle.
//  - LW addr 0x102 -> no mem_req; exc_valid, exc_code=01, exc_addr=0x102.
//  - SW addr 0x300, mem_ready never asserted, TIMEOUT_CYCLES=16
//    -> after 16 req cycles exc_code=11, mem_req=0.
//  - rst asserted mid-ACCESS -> mem_req=0 in the same cycle; no wb/exc after release; in_ready=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the Small_MIPS memory-access stage: op codes,
// exception codes and the stage FSM state encoding.
package mips_pkg;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDU = 6'b100001;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_NOP  = 6'b000000;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'b00,
    EXC_MIS_LD  = 2'b01,
    EXC_MIS_ST  = 2'b10,
    EXC_TIMEOUT = 2'b11
  } exc_code_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // True for the two op codes that touch data memory.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_stage.sv
// Memory-access stage downstream of the ALU. Loads and stores go out on a
// single-outstanding request/ready port; every other op is forwarded to
// writeback. Misaligned accesses and memory timeouts raise a one-cycle
// exception pulse instead of a writeback.
//
// Handshake: the input side transfers on a rising edge where
// in_valid & in_ready; in_ready is high exactly while the FSM is IDLE. The
// memory side completes on a rising edge where mem_req & mem_ready;
// mem_ready seen while mem_req is low is ignored. Writeback has no
// backpressure. dbg_state exposes the FSM state for observation.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_dest,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_addr,
  output state_t      dbg_state
);

  // Counter holds 0..TIMEOUT_CYCLES-1; the last value marks the final
  // ACCESS cycle allowed before the request is abandoned.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]  r_dest;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_wb_valid;
  logic        r_wb_we;
  logic [4:0]  r_wb_dest;
  logic [31:0] r_wb_data;
  logic        r_exc_valid;
  exc_code_t   r_exc_code;
  logic [31:0] r_exc_addr;

  logic w_accept;
  logic w_misaligned;
  logic w_timeout;

  assign w_accept     = in_valid && (r_state == IDLE);
  assign w_misaligned = (in_alu_result[1:0] != 2'b00);
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  assign in_ready  = (r_state == IDLE);
  // The request is the ACCESS state itself, so async reset removes it at once.
  assign mem_req   = (r_state == ACCESS);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_we     = r_wb_we;
  assign wb_dest   = r_wb_dest;
  assign wb_data   = r_wb_data;
  assign exc_valid = r_exc_valid;
  assign exc_code  = r_exc_code;
  assign exc_addr  = r_exc_addr;
  assign dbg_state = r_state;

  // FSM, timeout counter and all output registers; pulses default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dest      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_dest   <= '0;
      r_wb_data   <= '0;
      r_exc_valid <= 1'b0;
      r_exc_code  <= EXC_NONE;
      r_exc_addr  <= '0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_exc_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (is_mem_op(in_op)) begin
              if (w_misaligned) begin
                r_exc_valid <= 1'b1;
                r_exc_code  <= (in_op == OP_LW) ? EXC_MIS_LD : EXC_MIS_ST;
                r_exc_addr  <= in_alu_result;
              end else begin
                r_state     <= ACCESS;
                r_cnt       <= '0;
                r_dest      <= in_dest;
                r_mem_we    <= (in_op == OP_SW);
                r_mem_addr  <= in_alu_result;
                r_mem_wdata <= in_store_data;
              end
            end else if (in_op == OP_ADDU) begin
              r_wb_valid <= 1'b1;
              r_wb_we    <= (in_dest != 5'd0);
              r_wb_dest  <= in_dest;
              r_wb_data  <= in_alu_result;
            end
          end
        end
        ACCESS: begin
          // Completion wins over a timeout falling on the same edge.
          if (mem_ready) begin
            r_state <= IDLE;
            if (!r_mem_we) begin
              r_wb_valid <= 1'b1;
              r_wb_we    <= (r_dest != 5'd0);
              r_wb_dest  <= r_dest;
              r_wb_data  <= mem_rdata;
            end
          end else if (w_timeout) begin
            r_state     <= IDLE;
            r_exc_valid <= 1'b1;
            r_exc_code  <= EXC_TIMEOUT;
            r_exc_addr  <= r_mem_addr;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: inputs change and outputs are checked
// on the falling clock edge, well away from the active rising edge.
module tb_mem_access_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_dest;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic [31:0] exc_addr;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_dest(in_dest),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_addr(exc_addr),
    .dbg_state(dbg_state)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op for exactly one rising edge; returns at the following falling edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] res,
                       input logic [31:0] sdata, input logic [4:0] dest);
    in_valid      = 1'b1;
    in_op         = op;
    in_alu_result = res;
    in_store_data = sdata;
    in_dest       = dest;
    @(negedge clk);
    in_valid      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = OP_NOP; in_alu_result = '0;
    in_store_data = '0; in_dest = '0; mem_ready = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_wb_valid",  32'(wb_valid),  32'd0);
    chk("rst_exc_valid", 32'(exc_valid), 32'd0);
    chk("rst_state",     32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // ADDU r5 -> writeback next cycle
    issue(OP_ADDU, 32'h0000_1234, 32'h0, 5'd5);
    chk("addu_wb_valid", 32'(wb_valid), 32'd1);
    chk("addu_wb_we",    32'(wb_we),    32'd1);
    chk("addu_wb_dest",  32'(wb_dest),  32'd5);
    chk("addu_wb_data",  wb_data,       32'h0000_1234);
    chk("addu_exc",      32'(exc_valid), 32'd0);
    @(negedge clk);
    chk("addu_pulse",    32'(wb_valid), 32'd0);

    // ADDU to r0: writeback pulse but no register write
    issue(OP_ADDU, 32'h0000_00FF, 32'h0, 5'd0);
    chk("addu_r0_valid", 32'(wb_valid), 32'd1);
    chk("addu_r0_we",    32'(wb_we),    32'd0);

    // NOP and JR: nothing happens
    issue(OP_NOP, 32'h1111_1111, 32'h0, 5'd4);
    chk("nop_wb", 32'(wb_valid), 32'd0);
    issue(OP_JR, 32'h2222_2220, 32'h0, 5'd4);
    chk("jr_wb",  32'(wb_valid), 32'd0);
    chk("jr_exc", 32'(exc_valid), 32'd0);

    // mem_ready while idle is ignored
    mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("idle_ready_wb", 32'(wb_valid), 32'd0);

    // LW r3 @0x100, three wait cycles then ready with 0xDEADBEEF
    issue(OP_LW, 32'h0000_0100, 32'h0, 5'd3);
    for (int i = 0; i < 4; i++) begin
      chk("lw_req",      32'(mem_req),  32'd1);
      chk("lw_addr",     mem_addr,      32'h0000_0100);
      chk("lw_we",       32'(mem_we),   32'd0);
      chk("lw_in_ready", 32'(in_ready), 32'd0);
      if (i == 3) begin
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    chk("lw_req_drop",  32'(mem_req),  32'd0);
    chk("lw_wb_valid",  32'(wb_valid), 32'd1);
    chk("lw_wb_we",     32'(wb_we),    32'd1);
    chk("lw_wb_dest",   32'(wb_dest),  32'd3);
    chk("lw_wb_data",   wb_data,       32'hDEAD_BEEF);
    chk("lw_in_ready",  32'(in_ready), 32'd1);

    // LW to r0 with ready in the first request cycle: 2-cycle latency, no reg write
    issue(OP_LW, 32'h0000_0040, 32'h0, 5'd0);
    mem_ready = 1'b1; mem_rdata = 32'h0000_ABCD;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("lw0_wb_valid", 32'(wb_valid), 32'd1);
    chk("lw0_wb_we",    32'(wb_we),    32'd0);
    chk("lw0_wb_data",  wb_data,       32'h0000_ABCD);

    // SW @0x204, ready in the first request cycle
    issue(OP_SW, 32'h0000_0204, 32'hA5A5_A5A5, 5'd0);
    chk("sw_req",   32'(mem_req), 32'd1);
    chk("sw_we",    32'(mem_we),  32'd1);
    chk("sw_addr",  mem_addr,     32'h0000_0204);
    chk("sw_wdata", mem_wdata,    32'hA5A5_A5A5);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("sw_req_drop", 32'(mem_req),  32'd0);
    chk("sw_no_wb",    32'(wb_valid), 32'd0);
    chk("sw_in_ready", 32'(in_ready), 32'd1);

    // Misaligned LW and SW
    issue(OP_LW, 32'h0000_0102, 32'h0, 5'd3);
    chk("mis_lw_req",  32'(mem_req),   32'd0);
    chk("mis_lw_exc",  32'(exc_valid), 32'd1);
    chk("mis_lw_code", 32'(exc_code),  32'd1);
    chk("mis_lw_addr", exc_addr,       32'h0000_0102);
    chk("mis_lw_rdy",  32'(in_ready),  32'd1);
    chk("mis_lw_wb",   32'(wb_valid),  32'd0);
    issue(OP_SW, 32'h0000_0301, 32'h1234_5678, 5'd0);
    chk("mis_sw_exc",  32'(exc_valid), 32'd1);
    chk("mis_sw_code", 32'(exc_code),  32'd2);
    chk("mis_sw_addr", exc_addr,       32'h0000_0301);
    @(negedge clk);
    chk("mis_pulse",   32'(exc_valid), 32'd0);

    // SW @0x300 that never completes: 16 request cycles then timeout
    issue(OP_SW, 32'h0000_0300, 32'hCAFE_0000, 5'd0);
    for (int i = 0; i < 16; i++) begin
      chk("to_req", 32'(mem_req), 32'd1);
      @(negedge clk);
    end
    chk("to_req_drop", 32'(mem_req),   32'd0);
    chk("to_exc",      32'(exc_valid), 32'd1);
    chk("to_code",     32'(exc_code),  32'd3);
    chk("to_addr",     exc_addr,       32'h0000_0300);
    chk("to_no_wb",    32'(wb_valid),  32'd0);
    chk("to_in_ready", 32'(in_ready),  32'd1);

    // LW whose ready lands on the timeout edge: completion wins
    issue(OP_LW, 32'h0000_0500, 32'h0, 5'd7);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    chk("edge_wb_valid", 32'(wb_valid),  32'd1);
    chk("edge_wb_data",  wb_data,        32'h0BAD_F00D);
    chk("edge_wb_dest",  32'(wb_dest),   32'd7);
    chk("edge_no_exc",   32'(exc_valid), 32'd0);

    // Reset in the middle of an access
    issue(OP_LW, 32'h0000_0400, 32'h0, 5'd9);
    chk("mid_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1 chk("mid_req_async", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mid_wb",    32'(wb_valid),  32'd0);
      chk("mid_exc",   32'(exc_valid), 32'd0);
      chk("mid_rdy",   32'(in_ready),  32'd1);
      chk("mid_req0",  32'(mem_req),   32'd0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
